neureka_accumulator_streamout: RTL and testbench

- Drain side of the accumulator bank.
- On a start pulse, it snapshots the NADD signed accumulators written by the accumulator adder into a shadow register.
- It then streams them out EPB elements per beat over a valid/ready interface towards the streamer/normquant.
- Optionally saturates each element; pulses a clear to the bank so accumulation of the next tile overlaps the drain.

---
 rtl/neureka_accumulator_streamout.sv | 155 +++++++++++++++
 tb/tb_neureka_accumulator_streamout.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neureka_accumulator_streamout.sv
// Accumulator bank drain: snapshots the bank on start and streams it out EPB elements per beat.
// Optional per-element signed saturation to QNT bits is enabled by defining NEUREKA_ACC_STREAMOUT_SAT_EN.
module neureka_accumulator_streamout #(
  // Defaults mirror neureka_package::NEUREKA_TP_OUT and NEUREKA_ACCUM_SIZE.
  parameter int NADD = 32,
  parameter int ACC  = 32,
  parameter int EPB  = 4,
  parameter int QNT  = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    test_mode_i,
  input  logic                    clear_i,
  input  logic                    start_i,
  input  logic [$clog2(NADD+1)-1:0] count_i,
  input  logic [NADD*ACC-1:0]     accumulator_i,
  output logic                    acc_clear_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    stream_valid_o,
  input  logic                    stream_ready_i,
  output logic [EPB*ACC-1:0]      stream_data_o,
  output logic [EPB*ACC/8-1:0]    stream_strb_o,
  output logic                    stream_last_o
);

  // state  | meaning
  // IDLE   | waiting for start_i
  // STREAM | presenting beats from the shadow copy
  // DONE   | one-cycle completion pulse

  localparam int CW  = $clog2(NADD+1);
  localparam int NB  = NADD / EPB;
  localparam int BW  = (NB > 1) ? $clog2(NB) : 1;
  localparam int IW  = (NADD > 1) ? $clog2(NADD) : 1;
  localparam int BPE = ACC / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_e;

  state_e                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [BW-1:0]            beat_q, beat_d;
  logic [BW-1:0]            last_beat_q, last_beat_d;
  logic [NADD-1:0][ACC-1:0] shadow_q, shadow_d;

  logic [CW-1:0]            cnt_clamp;
  logic [31:0]              nbeats_m1;
  logic                     capture;

  logic [EPB-1:0][ACC-1:0]  data_w;
  logic [EPB-1:0][BPE-1:0]  strb_w;

  logic unused_test_mode;
  assign unused_test_mode = test_mode_i;

`ifdef NEUREKA_ACC_STREAMOUT_SAT_EN
  function automatic logic [ACC-1:0] sat_elem(input logic [ACC-1:0] v);
    logic signed [ACC-1:0] hi;
    logic signed [ACC-1:0] lo;
    hi = signed'((ACC'(1) << (QNT-1)) - ACC'(1));
    lo = ~hi;
    if ($signed(v) > hi) return hi;
    if ($signed(v) < lo) return lo;
    return v;
  endfunction
`else
  localparam int unused_qnt = QNT;

  function automatic logic [ACC-1:0] sat_elem(input logic [ACC-1:0] v);
    return v;
  endfunction
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      beat_q      <= '0;
      last_beat_q <= '0;
      shadow_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      beat_q      <= beat_d;
      last_beat_q <= last_beat_d;
      shadow_q    <= shadow_d;
    end
  end

  always_comb begin
    cnt_clamp   = (int'(count_i) > NADD) ? CW'(NADD) : count_i;
    nbeats_m1   = (32'(cnt_clamp) + 32'(EPB) - 32'd1) / 32'(EPB) - 32'd1;
    state_d     = state_q;
    cnt_d       = cnt_q;
    beat_d      = beat_q;
    last_beat_d = last_beat_q;
    shadow_d    = shadow_q;
    capture     = 1'b0;
    // Soft clear wins over everything, including a same-cycle start.
    if (clear_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            cnt_d = cnt_clamp;
            if (cnt_clamp == '0) begin
              state_d = DONE;
            end else begin
              capture     = 1'b1;
              shadow_d    = accumulator_i;
              beat_d      = '0;
              last_beat_d = BW'(nbeats_m1);
              state_d     = STREAM;
            end
          end
        end
        STREAM: begin
          if (stream_ready_i) begin
            if (beat_q == last_beat_q) state_d = DONE;
            else                       beat_d  = beat_q + BW'(1);
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    logic [IW-1:0] idx;
    stream_valid_o = (state_q == STREAM);
    stream_last_o  = stream_valid_o && (beat_q == last_beat_q);
    done_o         = (state_q == DONE);
    busy_o         = (state_q != IDLE);
    acc_clear_o    = capture && !rst_i;
    data_w         = '0;
    strb_w         = '0;
    for (int e = 0; e < EPB; e++) begin
      idx = IW'(32'(beat_q) * 32'(EPB) + 32'(e));
      // Elements past the latched count are padding: zero data, zero strobe.
      if (stream_valid_o && (32'(idx) < 32'(cnt_q))) begin
        data_w[e] = sat_elem(shadow_q[idx]);
        strb_w[e] = '1;
      end
    end
    stream_data_o = data_w;
    stream_strb_o = strb_w;
  end

endmodule

// File: tb/tb_neureka_accumulator_streamout.sv
// Bench for neureka_accumulator_streamout: vector table of drains plus clear/reset sequences,
// with a queue scoreboard of expected beats consumed by a stream monitor.
module tb_neureka_accumulator_streamout;

  localparam int NADD = 32;
  localparam int ACC  = 32;
  localparam int EPB  = 4;
  localparam int QNT  = 16;
  localparam int CW   = $clog2(NADD+1);
  localparam int SB   = EPB*ACC/8;
  localparam int DW   = EPB*ACC;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              test_mode_i;
  logic              clear_i;
  logic              start_i;
  logic [CW-1:0]     count_i;
  logic [NADD*ACC-1:0] accumulator_i;
  logic              acc_clear_o;
  logic              busy_o;
  logic              done_o;
  logic              stream_valid_o;
  logic              stream_ready_i;
  logic [DW-1:0]     stream_data_o;
  logic [SB-1:0]     stream_strb_o;
  logic              stream_last_o;

  typedef struct {
    logic [DW-1:0] data;
    logic [SB-1:0] strb;
    logic          last;
  } beat_t;

  typedef struct {
    int count;
    int ready_mode;
    int fill;
    int exp_beats;
  } vec_t;

  beat_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int done_seen = 0;
  int clr_seen = 0;
  logic signed [ACC-1:0] bank [NADD];

  neureka_accumulator_streamout #(
    .NADD(NADD), .ACC(ACC), .EPB(EPB), .QNT(QNT)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .test_mode_i    (test_mode_i),
    .clear_i        (clear_i),
    .start_i        (start_i),
    .count_i        (count_i),
    .accumulator_i  (accumulator_i),
    .acc_clear_o    (acc_clear_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .stream_valid_o (stream_valid_o),
    .stream_ready_i (stream_ready_i),
    .stream_data_o  (stream_data_o),
    .stream_strb_o  (stream_strb_o),
    .stream_last_o  (stream_last_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [ACC-1:0] model_sat(input logic signed [ACC-1:0] v);
`ifdef NEUREKA_ACC_STREAMOUT_SAT_EN
    longint hi;
    hi = (longint'(1) <<< (QNT-1)) - 1;
    if (longint'(v) > hi) return ACC'(hi);
    if (longint'(v) < -hi - 1) return ACC'(-hi - 1);
`endif
    return v;
  endfunction

  task automatic load_bank(input int fill);
    for (int i = 0; i < NADD; i++) begin
      case (fill)
        0: bank[i] = ACC'(i);
        1: bank[i] = ACC'($urandom);
        default: begin
          case (i % 4)
            0: bank[i] = 40000;
            1: bank[i] = -40000;
            2: bank[i] = 1234;
            default: bank[i] = -(i + 1);
          endcase
        end
      endcase
    end
  endtask

  task automatic drive_bank();
    for (int i = 0; i < NADD; i++) accumulator_i[i*ACC +: ACC] = bank[i];
  endtask

  task automatic push_expected(input int cnt);
    int c;
    int nb;
    beat_t x;
    c  = (cnt > NADD) ? NADD : cnt;
    nb = (c + EPB - 1) / EPB;
    for (int b = 0; b < nb; b++) begin
      x.data = '0;
      x.strb = '0;
      for (int e = 0; e < EPB; e++) begin
        if (b*EPB + e < c) begin
          x.data[e*ACC +: ACC]     = model_sat(bank[b*EPB + e]);
          x.strb[e*(ACC/8) +: ACC/8] = '1;
        end
      end
      x.last = (b == nb - 1);
      exp_q.push_back(x);
    end
  endtask

  // Every valid beat is compared to the head of the scoreboard; a handshake retires it.
  always @(negedge clk_i) begin
    if (done_o) done_seen++;
    if (acc_clear_o) clr_seen++;
    if (stream_valid_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got data %h with no beat expected", stream_data_o);
      end else begin
        chk("beat_data", stream_data_o, exp_q[0].data);
        chk("beat_strb", DW'(stream_strb_o), DW'(exp_q[0].strb));
        chk("beat_last", DW'(stream_last_o), DW'(exp_q[0].last));
        if (stream_ready_i) exp_q.delete(0);
      end
    end
  end

  task automatic run_drain(input vec_t v);
    int cycles;
    int c;
    int clr0;
    int pat [4];
    pat = '{1, 0, 0, 1};
    c = (v.count > NADD) ? NADD : v.count;
    load_bank(v.fill);
    drive_bank();
    push_expected(v.count);
    clr0 = clr_seen;
    start_i = 1'b1;
    count_i = CW'(v.count);
    stream_ready_i = 1'b1;
    #1;
    chk("acc_clear_capture", DW'(acc_clear_o), DW'(c > 0));
    chk("busy_before_start", DW'(busy_o), DW'(0));
    @(posedge clk_i); #1;
    start_i = 1'b0;
    // Rewrite the bank after capture; the shadow copy must be what streams out.
    for (int i = 0; i < NADD; i++) bank[i] = ~bank[i];
    drive_bank();
    cycles = 1;
    while (!done_o && cycles < 200) begin
      stream_ready_i = (v.ready_mode == 0) ? 1'b1 : pat[cycles % 4][0];
      @(posedge clk_i); #1;
      cycles++;
    end
    if (cycles >= 200) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done_o after %0d cycles, required one", cycles);
    end
    if (v.ready_mode == 0) chk("done_latency", DW'(cycles), DW'(1 + v.exp_beats));
    else                   chk("done_latency_min", DW'(cycles >= 1 + v.exp_beats), DW'(1));
    chk("beats_remaining", DW'(exp_q.size()), DW'(0));
    @(posedge clk_i); #1;
    chk("done_one_cycle", DW'(done_o), DW'(0));
    chk("idle_after_done", DW'(busy_o), DW'(0));
    chk("acc_clear_pulses", DW'(clr_seen - clr0), DW'(c > 0));
    stream_ready_i = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [9];
    int d0;
    int c0;
    vecs[0] = '{32, 0, 0, 8};
    vecs[1] = '{6,  0, 0, 2};
    vecs[2] = '{0,  0, 0, 0};
    vecs[3] = '{40, 0, 1, 8};
    vecs[4] = '{32, 1, 1, 8};
    vecs[5] = '{5,  1, 2, 2};
    vecs[6] = '{4,  0, 2, 1};
    vecs[7] = '{1,  0, 1, 1};
    vecs[8] = '{31, 1, 1, 8};

    rst_i = 1'b1;
    test_mode_i = 1'b0;
    clear_i = 1'b0;
    start_i = 1'b0;
    count_i = '0;
    accumulator_i = '0;
    stream_ready_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_valid", DW'(stream_valid_o), DW'(0));
    chk("rst_last", DW'(stream_last_o), DW'(0));
    chk("rst_done", DW'(done_o), DW'(0));
    chk("rst_busy", DW'(busy_o), DW'(0));
    chk("rst_acc_clear", DW'(acc_clear_o), DW'(0));
    chk("rst_data", stream_data_o, DW'(0));
    chk("rst_strb", DW'(stream_strb_o), DW'(0));
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    for (int v = 0; v < 9; v++) run_drain(vecs[v]);

    // Soft clear while beat 3 is stalled on the interface.
    load_bank(1);
    drive_bank();
    push_expected(32);
    d0 = done_seen;
    start_i = 1'b1;
    count_i = CW'(32);
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (3) begin
      @(posedge clk_i); #1;
    end
    stream_ready_i = 1'b0;
    clear_i = 1'b1;
    chk("clr_mid_valid", DW'(stream_valid_o), DW'(1));
    @(posedge clk_i); #1;
    clear_i = 1'b0;
    chk("clr_mid_valid_after", DW'(stream_valid_o), DW'(0));
    chk("clr_mid_busy_after", DW'(busy_o), DW'(0));
    chk("clr_mid_last_after", DW'(stream_last_o), DW'(0));
    chk("clr_mid_done_after", DW'(done_o), DW'(0));
    exp_q.delete();
    stream_ready_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    chk("clr_mid_no_done", DW'(done_seen - d0), DW'(0));
    run_drain('{8, 0, 1, 2});

    // Clear together with start in IDLE: nothing is captured.
    load_bank(2);
    drive_bank();
    d0 = done_seen;
    c0 = clr_seen;
    start_i = 1'b1;
    clear_i = 1'b1;
    count_i = CW'(8);
    #1;
    chk("clr_start_acc_clear", DW'(acc_clear_o), DW'(0));
    @(posedge clk_i); #1;
    start_i = 1'b0;
    clear_i = 1'b0;
    chk("clr_start_busy", DW'(busy_o), DW'(0));
    chk("clr_start_valid", DW'(stream_valid_o), DW'(0));
    repeat (2) @(posedge clk_i);
    #1;
    chk("clr_start_no_done", DW'(done_seen - d0), DW'(0));
    chk("clr_start_no_clear", DW'(clr_seen - c0), DW'(0));
    run_drain('{12, 1, 2, 3});

    // Asynchronous reset in the middle of a stream.
    load_bank(0);
    drive_bank();
    push_expected(32);
    start_i = 1'b1;
    count_i = CW'(32);
    @(posedge clk_i); #1;
    start_i = 1'b0;
    @(posedge clk_i); #1;
    d0 = done_seen;
    rst_i = 1'b1;
    #1;
    chk("rst_mid_valid", DW'(stream_valid_o), DW'(0));
    chk("rst_mid_busy", DW'(busy_o), DW'(0));
    chk("rst_mid_last", DW'(stream_last_o), DW'(0));
    chk("rst_mid_data", stream_data_o, DW'(0));
    exp_q.delete();
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_mid_no_done", DW'(done_seen - d0), DW'(0));
    run_drain('{32, 0, 0, 8});

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
